// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of an async signal over a fixed clk window,
// saturates the result and converts it to 4-digit BCD with a sequential double-dabble.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned MAX_COUNT   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sig_in,
  output logic [13:0] freq,
  output logic [15:0] bcd,
  output logic        overflow,
  output logic        valid
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GateLast = GW'(GATE_CYCLES - 1);
  localparam logic [13:0]   MaxCnt   = 14'(MAX_COUNT);
  localparam logic [13:0]   EdgeSat  = 14'h3fff;

  typedef enum logic [1:0] {StMeasure, StConvert, StDone} state_t;

  state_t        state_q;
  logic          sync1_q, sync2_q, hist_q;
  logic [GW-1:0] gate_cnt_q;
  logic [13:0]   edge_cnt_q;
  logic [13:0]   cap_q;
  logic          ovf_cap_q;
  logic [13:0]   bin_q;
  logic [15:0]   bcd_sh_q;
  logic [3:0]    bit_cnt_q;

  logic          rise;
  logic [13:0]   edge_next;
  logic [13:0]   final_sat;
  logic          final_ovf;
  logic [15:0]   bcd_adj;
  logic [15:0]   bcd_shift;

  assign rise = sync2_q & ~hist_q;

  // Edge counter sticks at all-ones instead of wrapping.
  always_comb begin
    edge_next = edge_cnt_q;
    if (rise && (edge_cnt_q != EdgeSat)) begin
      edge_next = edge_cnt_q + 14'd1;
    end
    final_ovf = (edge_next > MaxCnt);
    final_sat = final_ovf ? MaxCnt : edge_next;
  end

  always_comb begin
    bcd_adj = bcd_sh_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[14:0], bin_q[13]};
  end

  // Synchronizer and history stay live while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StMeasure;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      cap_q      <= '0;
      ovf_cap_q  <= 1'b0;
      bin_q      <= '0;
      bcd_sh_q   <= '0;
      bit_cnt_q  <= '0;
      freq       <= '0;
      bcd        <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
    end else if (!en) begin
      state_q    <= StMeasure;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      cap_q      <= '0;
      ovf_cap_q  <= 1'b0;
      bin_q      <= '0;
      bcd_sh_q   <= '0;
      bit_cnt_q  <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        StMeasure: begin
          if (gate_cnt_q == GateLast) begin
            cap_q      <= final_sat;
            ovf_cap_q  <= final_ovf;
            bin_q      <= final_sat;
            bcd_sh_q   <= '0;
            bit_cnt_q  <= '0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            state_q    <= StConvert;
          end else begin
            gate_cnt_q <= gate_cnt_q + GW'(1);
            edge_cnt_q <= edge_next;
          end
        end
        StConvert: begin
          bcd_sh_q  <= bcd_shift;
          bin_q     <= {bin_q[12:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 4'd1;
          // Outputs load on the last shift so they are visible with valid in StDone.
          if (bit_cnt_q == 4'd13) begin
            freq     <= cap_q;
            bcd      <= bcd_shift;
            overflow <= ovf_cap_q;
            valid    <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          state_q <= StMeasure;
        end
        default: begin
          state_q <= StMeasure;
        end
      endcase
    end
  end

endmodule
